lfsr_seq_checker: RTL and testbench

- Downstream consumer of the 6-bit dff-built LFSR; samples its state bus `q` every enabled cycle.
- Predicts each next state from the previous one and acquires lock on the sequence.
- Flags and counts deviations from the expected sequence, and detects the dead all-zero state.
- Provides a built-in self-check for the LFSR in the test datapath.

---
 rtl/lfsr_pkg.sv | 19 +
 rtl/lfsr_seq_checker.sv | 161 ++++++++++++++++
 tb/tb_lfsr_seq_checker.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 6-bit Galois LFSR (x^6+x^3+1) and its consumers.
// Holds the step function so the generator, checker and any MISR agree on one polynomial.
package lfsr_pkg;

    localparam int              LFSR_W   = 6;
    localparam logic [LFSR_W-1:0] TAP_MASK = 6'b001000;
    localparam logic [LFSR_W-1:0] SEED     = 6'h3F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
        return {x[LFSR_W-2:0], x[LFSR_W-1]} ^ (x[LFSR_W-1] ? TAP_MASK : '0);
    endfunction

endpackage

// File: rtl/lfsr_seq_checker.sv
// LFSR sequence checker: acquires lock, flywheels through misses, counts errors, flags all-zero state.
// Outputs registered (1 cycle), no backpressure; LFSR_SEQ_CHECKER_PERIOD_MEAS_EN adds the period port.
module lfsr_seq_checker
    import lfsr_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              valid,
    input  logic [5:0]        q_in,
    input  logic              clr,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              stuck
`ifdef LFSR_SEQ_CHECKER_PERIOD_MEAS_EN
    ,
    output logic [7:0]        period
`endif
);

    state_t            state;
    state_t            state_nxt;
    logic [LFSR_W-1:0] prev;
    logic [LFSR_W-1:0] pred;
    logic [3:0]        match_cnt;
    logic [3:0]        miss_cnt;
    logic              zero;
    logic              hit;
    logic              lock_now;
    logic              loss_now;
    logic              miss_evt;

    assign pred     = lfsr_step(prev);
    assign zero     = (q_in == '0);
    assign hit      = (q_in == pred) && !zero;
    assign miss_evt = valid && (state == LOCKED) && !hit;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lock_now  = 1'b0;
        loss_now  = 1'b0;
        if (valid) begin
            case (state)
                IDLE: state_nxt = SYNC;
                SYNC: begin
                    if (hit && (match_cnt == 4'(LOCK_CNT - 1))) begin
                        state_nxt = LOCKED;
                        lock_now  = 1'b1;
                    end
                end
                LOCKED: begin
                    if (!hit && (miss_cnt == 4'(LOSS_CNT - 1))) begin
                        state_nxt = SYNC;
                        loss_now  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        locked = (state == LOCKED);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            prev      <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
        end else if (valid) begin
            case (state)
                IDLE: begin
                    prev      <= q_in;
                    match_cnt <= '0;
                end
                SYNC: begin
                    prev      <= q_in;
                    match_cnt <= hit ? match_cnt + 4'd1 : 4'd0;
                    if (lock_now) begin
                        miss_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (hit) begin
                        prev     <= q_in;
                        miss_cnt <= '0;
                    end else if (loss_now) begin
                        // Resync from the sample, but a zero sample would trap SYNC, so keep flywheeling.
                        prev      <= zero ? pred : q_in;
                        match_cnt <= '0;
                        miss_cnt  <= '0;
                    end else begin
                        prev     <= pred;
                        miss_cnt <= miss_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err     <= 1'b0;
            err_cnt <= '0;
            stuck   <= 1'b0;
        end else begin
            err <= miss_evt;
            if (clr) begin
                err_cnt <= '0;
                stuck   <= 1'b0;
            end else begin
                if (miss_evt && (err_cnt != '1)) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                if (valid && zero) begin
                    stuck <= 1'b1;
                end
            end
        end
    end

`ifdef LFSR_SEQ_CHECKER_PERIOD_MEAS_EN
    logic [LFSR_W-1:0] ref_q;
    logic [7:0]        samp_cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ref_q    <= '0;
            samp_cnt <= '0;
            period   <= '0;
        end else if (valid) begin
            if (lock_now) begin
                ref_q    <= q_in;
                samp_cnt <= '0;
            end else if (state == LOCKED) begin
                if (q_in == ref_q) begin
                    period   <= (samp_cnt == 8'hFF) ? 8'hFF : samp_cnt + 8'd1;
                    samp_cnt <= '0;
                end else if (samp_cnt != 8'hFF) begin
                    samp_cnt <= samp_cnt + 8'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Bench for lfsr_seq_checker: directed scenarios then random traffic against a behavioural model.
// Instance a uses defaults; instance b uses ERR_W=2, LOSS_CNT=15 to reach saturation.
module tb_lfsr_seq_checker;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       valid;
    logic [5:0] q_in;
    logic       clr;

    logic       a_locked, a_err, a_stuck;
    logic [7:0] a_err_cnt;
    logic       b_locked, b_err, b_stuck;
    logic [1:0] b_err_cnt;
`ifdef LFSR_SEQ_CHECKER_PERIOD_MEAS_EN
    logic [7:0] a_period, b_period;
`endif

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    lfsr_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(3), .ERR_W(8)) u_a (
        .clk(clk), .rst_b(rst_b), .valid(valid), .q_in(q_in), .clr(clr),
        .locked(a_locked), .err(a_err), .err_cnt(a_err_cnt), .stuck(a_stuck)
`ifdef LFSR_SEQ_CHECKER_PERIOD_MEAS_EN
        , .period(a_period)
`endif
    );

    lfsr_seq_checker #(.LOCK_CNT(4), .LOSS_CNT(15), .ERR_W(2)) u_b (
        .clk(clk), .rst_b(rst_b), .valid(valid), .q_in(q_in), .clr(clr),
        .locked(b_locked), .err(b_err), .err_cnt(b_err_cnt), .stuck(b_stuck)
`ifdef LFSR_SEQ_CHECKER_PERIOD_MEAS_EN
        , .period(b_period)
`endif
    );

    // Behavioural model: 0 = waiting for first sample, 1 = hunting, 2 = locked.
    int lock_n [2] = '{4, 4};
    int loss_n [2] = '{3, 15};
    int emax   [2] = '{255, 3};
    int mode [2], prev [2], run [2], bad [2], errc [2], stk [2], erp [2];
    int per [2], pcnt [2], refv [2];

    // Multiply by x modulo x^6 + x^3 + 1.
    function automatic int stepf(input int x);
        int y;
        y = x * 2;
        if (y >= 64) y = y ^ 73;
        return y;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mode[i] = 0; prev[i] = 0; run[i] = 0; bad[i] = 0; errc[i] = 0;
            stk[i] = 0; erp[i] = 0; per[i] = 0; pcnt[i] = 0; refv[i] = 0;
        end
    endtask

    task automatic model_update(input logic v, input logic [5:0] qv, input logic c);
        int q;
        q = int'(qv);
        for (int i = 0; i < 2; i++) begin
            erp[i] = 0;
            if (v) begin
                if (q == 0) stk[i] = 1;
                if (mode[i] == 0) begin
                    prev[i] = q; mode[i] = 1; run[i] = 0;
                end else if (mode[i] == 1) begin
                    if (q != 0 && q == stepf(prev[i])) begin
                        run[i]++;
                        if (run[i] == lock_n[i]) begin
                            mode[i] = 2; bad[i] = 0; refv[i] = q; pcnt[i] = 0;
                        end
                    end else begin
                        run[i] = 0;
                    end
                    prev[i] = q;
                end else begin
                    if (q == refv[i]) begin
                        per[i] = (pcnt[i] + 1 > 255) ? 255 : pcnt[i] + 1;
                        pcnt[i] = 0;
                    end else if (pcnt[i] < 255) begin
                        pcnt[i]++;
                    end
                    if (q != 0 && q == stepf(prev[i])) begin
                        prev[i] = q; bad[i] = 0;
                    end else begin
                        erp[i] = 1;
                        if (errc[i] < emax[i]) errc[i]++;
                        bad[i]++;
                        if (bad[i] == loss_n[i]) begin
                            mode[i] = 1; run[i] = 0; bad[i] = 0;
                            prev[i] = (q != 0) ? q : stepf(prev[i]);
                        end else begin
                            prev[i] = stepf(prev[i]);
                        end
                    end
                end
            end
            if (c) begin
                errc[i] = 0; stk[i] = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("a.locked",  32'(a_locked),  32'(mode[0] == 2));
        chk("a.err",     32'(a_err),     32'(erp[0]));
        chk("a.err_cnt", 32'(a_err_cnt), 32'(errc[0]));
        chk("a.stuck",   32'(a_stuck),   32'(stk[0]));
        chk("b.locked",  32'(b_locked),  32'(mode[1] == 2));
        chk("b.err",     32'(b_err),     32'(erp[1]));
        chk("b.err_cnt", 32'(b_err_cnt), 32'(errc[1]));
        chk("b.stuck",   32'(b_stuck),   32'(stk[1]));
`ifdef LFSR_SEQ_CHECKER_PERIOD_MEAS_EN
        chk("a.period",  32'(a_period),  32'(per[0]));
        chk("b.period",  32'(b_period),  32'(per[1]));
`endif
    endtask

    task automatic drive(input logic v, input logic [5:0] q, input logic c);
        valid = v; q_in = q; clr = c;
        @(posedge clk);
        model_update(v, q, c);
        #1;
        check_all();
    endtask

    task automatic async_reset();
        rst_b = 1'b0;
        #2;
        model_reset();
        check_all();
        chk("rst_a_locked", 32'(a_locked), 32'd0);
        chk("rst_a_err_cnt", 32'(a_err_cnt), 32'd0);
        rst_b = 1'b1;
        #1;
    endtask

    task automatic drive_seq(input logic [5:0] seq [], input logic c);
        for (int k = 0; k < seq.size(); k++) drive(1'b1, seq[k], c);
    endtask

    initial begin
        logic [5:0] acq [];
        logic [5:0] cyc [];
        logic [5:0] q;
        logic       v, c;
        int         r;

        rst_b = 1'b0; valid = 1'b0; q_in = '0; clr = 1'b0;
        model_reset();
        #12;
        check_all();
        rst_b = 1'b1;

        // Acquisition
        acq = '{6'h3F, 6'h37, 6'h27, 6'h07};
        drive_seq(acq, 1'b0);
        chk("acq_not_yet_locked", 32'(a_locked), 32'd0);
        drive(1'b1, 6'h0E, 1'b0);
        chk("acq_locked", 32'(a_locked), 32'd1);
        chk("acq_err_cnt", 32'(a_err_cnt), 32'd0);

        // Single error with flywheel
        drive(1'b1, 6'h1C, 1'b0);
        drive(1'b1, 6'h15, 1'b0);
        chk("fly_err", 32'(a_err), 32'd1);
        chk("fly_err_cnt", 32'(a_err_cnt), 32'd1);
        drive(1'b1, 6'h39, 1'b0);
        chk("fly_match_err", 32'(a_err), 32'd0);
        drive(1'b1, 6'h3B, 1'b0);
        chk("fly_locked", 32'(a_locked), 32'd1);

        // Idle cycle changes nothing
        drive(1'b0, 6'h00, 1'b0);
        chk("idle_stuck", 32'(a_stuck), 32'd0);

        // Loss of lock after three misses, then relock after 1 + 4 samples
        drive(1'b1, 6'h3F, 1'b1);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 6'h15, 1'b0);
            chk("loss_err_pulse", 32'(a_err), 32'd1);
        end
        chk("loss_err_cnt", 32'(a_err_cnt), 32'd3);
        chk("loss_unlocked", 32'(a_locked), 32'd0);
        acq = '{6'h0E, 6'h1C, 6'h38, 6'h39, 6'h3B};
        drive_seq(acq, 1'b0);
        chk("relock", 32'(a_locked), 32'd1);

        // Stuck and clear
        drive(1'b1, 6'h00, 1'b0);
        chk("stuck_set", 32'(a_stuck), 32'd1);
        chk("stuck_err", 32'(a_err), 32'd1);
        drive(1'b1, 6'h15, 1'b1);
        chk("clr_err_pulse", 32'(a_err), 32'd1);
        chk("clr_err_cnt", 32'(a_err_cnt), 32'd0);
        chk("clr_stuck", 32'(a_stuck), 32'd0);
        drive(1'b1, 6'h27, 1'b0);

        // Saturation on the narrow counter
        drive(1'b1, 6'h07, 1'b1);
        for (int k = 0; k < 6; k++) drive(1'b1, 6'h15, 1'b0);
        chk("sat_b_err_cnt", 32'(b_err_cnt), 32'd3);
        chk("sat_b_locked", 32'(b_locked), 32'd1);

        // Reset mid-stream
        drive(1'b1, 6'h3F, 1'b0);
        async_reset();

        // Period measurement
        acq = '{6'h3F, 6'h37, 6'h27, 6'h07, 6'h0E};
        cyc = '{6'h1C, 6'h38, 6'h39, 6'h3B, 6'h3F, 6'h37, 6'h27, 6'h07, 6'h0E};
        drive_seq(acq, 1'b0);
        drive_seq(cyc, 1'b0);
`ifdef LFSR_SEQ_CHECKER_PERIOD_MEAS_EN
        chk("period_9", 32'(a_period), 32'd9);
`endif

        // Random traffic, mostly on-sequence for instance a
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 999);
            if (r < 5) begin
                async_reset();
                continue;
            end
            v = ($urandom_range(0, 99) >= 8);
            c = ($urandom_range(0, 99) < 3);
            r = $urandom_range(0, 99);
            if (mode[0] == 0 || stepf(prev[0]) == 0 || r < 6) q = 6'($urandom_range(1, 63));
            else if (r < 8) q = 6'h00;
            else q = 6'(stepf(prev[0]));
            drive(v, q, c);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
